// File: rtl/period_detector_pkg.sv
// Shared widths, types and constants for the period detector.
// Contents:
//   AUDIO_BIT_WIDTH / PERIOD_WIDTH / PERCENT_WIDTH : datapath widths
//   percent_t                                      : duty-cycle fraction of full scale
//   period_detector_state_t                        : measurement FSM states
//   DIVIDE_CYCLES                                  : serial divider iteration count
package period_detector_pkg;

    localparam int unsigned AUDIO_BIT_WIDTH = 16;
    localparam int unsigned PERIOD_WIDTH    = 12;
    localparam int unsigned PERCENT_WIDTH   = 8;
    localparam int unsigned DIVIDE_CYCLES   = PERCENT_WIDTH;

    typedef logic [PERCENT_WIDTH-1:0] percent_t;

    typedef enum logic [1:0] {
        SEEK  = 2'd0,
        ARMED = 2'd1,
        HIGH  = 2'd2,
        LOW   = 2'd3
    } period_detector_state_t;

endpackage

// File: rtl/period_detector_divider.sv
// Restoring serial divider, one quotient bit per clock.
// The caller guarantees the quotient fits in DIVIDE_CYCLES bits, i.e. the
// upper PERIOD_WIDTH bits of the dividend are below the divisor, so the
// partial remainder never needs more than PERIOD_WIDTH bits.
// Ports:
//   clk_i, rst_i   : clock, synchronous active-high reset (aborts a division)
//   start_i        : load operands and begin (ignored semantics while busy are the caller's concern)
//   dividend_i     : PERIOD_WIDTH+DIVIDE_CYCLES bit dividend
//   divisor_i      : PERIOD_WIDTH bit divisor, nonzero
//   busy_o         : division in progress
//   done_o         : one-cycle pulse, quotient_o valid from this cycle until next start
//   quotient_o     : DIVIDE_CYCLES bit quotient
module serial_divider
    import period_detector_pkg::*;
(
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic                                  start_i,
    input  logic [PERIOD_WIDTH+DIVIDE_CYCLES-1:0] dividend_i,
    input  logic [PERIOD_WIDTH-1:0]               divisor_i,
    output logic                                  busy_o,
    output logic                                  done_o,
    output logic [DIVIDE_CYCLES-1:0]              quotient_o
);

    localparam int unsigned DW = PERIOD_WIDTH;
    localparam int unsigned QW = DIVIDE_CYCLES;
    localparam int unsigned CW = $clog2(DIVIDE_CYCLES + 1);

    logic [DW-1:0] rem_q,     rem_d;
    logic [QW-1:0] shift_q,   shift_d;
    logic [DW-1:0] divisor_q, divisor_d;
    logic [CW-1:0] count_q,   count_d;
    logic          busy_q,    busy_d;
    logic          done_q,    done_d;

    logic [DW:0]   trial_c;
    logic [DW:0]   diff_c;
    logic          ge_c;

    // Shift register holds the remaining dividend bits and collects quotient bits behind them.
    always_comb begin
        rem_d     = rem_q;
        shift_d   = shift_q;
        divisor_d = divisor_q;
        count_d   = count_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        trial_c   = {rem_q, shift_q[QW-1]};
        diff_c    = trial_c - {1'b0, divisor_q};
        ge_c      = (trial_c >= {1'b0, divisor_q});

        if (start_i) begin
            rem_d     = dividend_i[DW+QW-1:QW];
            shift_d   = dividend_i[QW-1:0];
            divisor_d = divisor_i;
            count_d   = CW'(QW);
            busy_d    = 1'b1;
        end else if (busy_q) begin
            rem_d   = ge_c ? diff_c[DW-1:0] : trial_c[DW-1:0];
            shift_d = {shift_q[QW-2:0], ge_c};
            count_d = count_q - CW'(1);
            if (count_q == CW'(1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rem_q     <= '0;
            shift_q   <= '0;
            divisor_q <= '0;
            count_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            rem_q     <= rem_d;
            shift_q   <= shift_d;
            divisor_q <= divisor_d;
            count_q   <= count_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign quotient_o = shift_q;

endmodule

// File: rtl/period_detector.sv
// Period and duty-cycle meter for a signed audio sample stream.
// Counts high and low samples between rising crossings, then divides
// high count by period to report duty cycle as a percent_t fraction.
// Optional feature: define PERIOD_DETECTOR_HYSTERESIS_EN to classify with
// +/-HYSTERESIS thresholds and a holding dead band; otherwise the sign bit
// alone decides high/low.
// Ports:
//   clock_50_000_000 : system clock
//   reset            : synchronous active-high reset
//   sample           : signed audio sample
//   sample_valid     : one-cycle strobe per sample
//   period           : last measured period in samples
//   duty_cycle       : floor(high * 2^PERCENT_WIDTH / period)
//   measure_valid    : one-cycle pulse when period/duty_cycle update
//   locked           : measurements are current
module period_detector
    import period_detector_pkg::*;
#(
    parameter int HYSTERESIS = 256
) (
    input  logic                       clock_50_000_000,
    input  logic                       reset,
    input  logic [AUDIO_BIT_WIDTH-1:0] sample,
    input  logic                       sample_valid,
    output logic [PERIOD_WIDTH-1:0]    period,
    output logic [PERCENT_WIDTH-1:0]   duty_cycle,
    output logic                       measure_valid,
    output logic                       locked
);

    localparam int unsigned AW = AUDIO_BIT_WIDTH;
    localparam int unsigned PW = PERIOD_WIDTH;
    localparam logic [PW-1:0] CNT_MAX = '1;

    period_detector_state_t state_q, state_d;
    logic          cls_high_q, cls_high_d;
    logic [PW-1:0] high_q,     high_d;
    logic [PW-1:0] low_q,      low_d;
    logic [PW-1:0] pend_q,     pend_d;
    logic [PW-1:0] period_q,   period_d;
    percent_t      duty_q,     duty_d;
    logic          mv_q,       mv_d;
    logic          locked_q,   locked_d;

    logic          is_high_c;
    logic          is_low_c;
    logic          rising_c;
    logic          overflow_c;
    logic          start_c;
    logic [PW:0]   sum_c;

    logic          div_busy;
    logic          div_done;
    percent_t      div_quot;

    // Sample classification.
`ifdef PERIOD_DETECTOR_HYSTERESIS_EN
    localparam logic signed [AW-1:0] HYST_HI = AW'(HYSTERESIS);
    localparam logic signed [AW-1:0] HYST_LO = AW'(-HYSTERESIS);

    assign is_high_c = ($signed(sample) >= HYST_HI);
    assign is_low_c  = ($signed(sample) <= HYST_LO);
`else
    logic [AW-2:0] unused_sample_bits;
    logic [31:0]   unused_hysteresis;

    assign is_high_c          = ~sample[AW-1];
    assign is_low_c           = sample[AW-1];
    assign unused_sample_bits = sample[AW-2:0];
    assign unused_hysteresis  = 32'(HYSTERESIS);
`endif

    // Dead-band samples inherit the previous class.
    always_comb begin
        cls_high_d = cls_high_q;
        if (sample_valid) begin
            if (is_high_c) begin
                cls_high_d = 1'b1;
            end else if (is_low_c) begin
                cls_high_d = 1'b0;
            end
        end
    end

    assign rising_c = sample_valid & ~cls_high_q & cls_high_d;
    assign sum_c    = {1'b0, high_q} + {1'b0, low_q};

    // Measurement FSM and output update.
    always_comb begin
        state_d    = state_q;
        high_d     = high_q;
        low_d      = low_q;
        pend_d     = pend_q;
        period_d   = period_q;
        duty_d     = duty_q;
        mv_d       = 1'b0;
        locked_d   = locked_q;
        start_c    = 1'b0;
        overflow_c = 1'b0;

        unique case (state_q)
            SEEK: begin
                if (sample_valid && is_low_c) begin
                    state_d = ARMED;
                end
            end
            ARMED: begin
                if (rising_c) begin
                    high_d  = PW'(1);
                    low_d   = '0;
                    state_d = HIGH;
                end
            end
            HIGH: begin
                if (sample_valid) begin
                    if (!cls_high_d) begin
                        low_d   = PW'(1);
                        state_d = LOW;
                    end else if (high_q == CNT_MAX) begin
                        overflow_c = 1'b1;
                    end else begin
                        high_d = high_q + PW'(1);
                    end
                end
            end
            LOW: begin
                if (rising_c) begin
                    // A period that cannot be reported is treated like a counter overflow.
                    if (sum_c > {1'b0, CNT_MAX}) begin
                        overflow_c = 1'b1;
                    end else begin
                        // A busy divider means the measurement is dropped; counting continues.
                        if (!div_busy) begin
                            start_c = 1'b1;
                            pend_d  = sum_c[PW-1:0];
                        end
                        high_d  = PW'(1);
                        low_d   = '0;
                        state_d = HIGH;
                    end
                end else if (sample_valid) begin
                    if (low_q == CNT_MAX) begin
                        overflow_c = 1'b1;
                    end else begin
                        low_d = low_q + PW'(1);
                    end
                end
            end
            default: begin
                state_d = SEEK;
            end
        endcase

        if (overflow_c) begin
            state_d  = SEEK;
            high_d   = '0;
            low_d    = '0;
            locked_d = 1'b0;
        end else if (div_done) begin
            period_d = pend_q;
            duty_d   = div_quot;
            mv_d     = 1'b1;
            locked_d = 1'b1;
        end
    end

    always_ff @(posedge clock_50_000_000) begin
        if (reset) begin
            state_q    <= SEEK;
            cls_high_q <= 1'b0;
            high_q     <= '0;
            low_q      <= '0;
            pend_q     <= '0;
            period_q   <= '0;
            duty_q     <= '0;
            mv_q       <= 1'b0;
            locked_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cls_high_q <= cls_high_d;
            high_q     <= high_d;
            low_q      <= low_d;
            pend_q     <= pend_d;
            period_q   <= period_d;
            duty_q     <= duty_d;
            mv_q       <= mv_d;
            locked_q   <= locked_d;
        end
    end

    serial_divider u_divider (
        .clk_i      (clock_50_000_000),
        .rst_i      (reset),
        .start_i    (start_c),
        .dividend_i ({high_q, {PERCENT_WIDTH{1'b0}}}),
        .divisor_i  (sum_c[PW-1:0]),
        .busy_o     (div_busy),
        .done_o     (div_done),
        .quotient_o (div_quot)
    );

    assign period        = period_q;
    assign duty_cycle    = duty_q;
    assign measure_valid = mv_q;
    assign locked        = locked_q;

endmodule

// File: tb/tb_period_detector.sv
// Directed-vector bench for period_detector: square waves, noise in the
// dead band, counter overflow, reset during a division and pulse latency.
module tb_period_detector;
    import period_detector_pkg::*;

    localparam logic signed [15:0] PMAX   = 16'sh7FFF;
    localparam logic signed [15:0] NMAX   = -16'sh7FFF;
    localparam logic signed [15:0] NOISEP = 16'sd255;
    localparam logic signed [15:0] NOISEN = -16'sd255;
    localparam int IDLE = 10;

    logic                       clk = 1'b0;
    logic                       reset;
    logic [AUDIO_BIT_WIDTH-1:0] sample;
    logic                       sample_valid;
    logic [PERIOD_WIDTH-1:0]    period;
    logic [PERCENT_WIDTH-1:0]   duty_cycle;
    logic                       measure_valid;
    logic                       locked;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int mv_count = 0;
    int mv_cyc = 0;
    int last_edge = 0;
    int base;

    period_detector #(.HYSTERESIS(256)) dut (
        .clock_50_000_000 (clk),
        .reset            (reset),
        .sample           (sample),
        .sample_valid     (sample_valid),
        .period           (period),
        .duty_cycle       (duty_cycle),
        .measure_valid    (measure_valid),
        .locked           (locked)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (measure_valid) begin
            mv_count = mv_count + 1;
            mv_cyc   = cyc;
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic send(input logic signed [15:0] s, input int idle);
        sample       = s;
        sample_valid = 1'b1;
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
        last_edge    = cyc;
        repeat (idle) @(posedge clk);
        #1;
    endtask

    task automatic send_n(input logic signed [15:0] s, input int n, input int idle);
        for (int i = 0; i < n; i++) send(s, idle);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset        = 1'b0;
        sample       = '0;
        sample_valid = 1'b0;
        do_reset();

        check("rst_period", int'(period), 0);
        check("rst_duty", int'(duty_cycle), 0);
        check("rst_mv", int'(measure_valid), 0);
        check("rst_locked", int'(locked), 0);

        // 4/4 square wave, three cycles
        base = mv_count;
        send_n(NMAX, 4, IDLE);
        send_n(PMAX, 4, IDLE);
        send_n(NMAX, 4, IDLE);
        check("sq_prelock_locked", int'(locked), 0);
        check("sq_prelock_pulses", mv_count - base, 0);
        send_n(PMAX, 4, IDLE);
        send_n(NMAX, 4, IDLE);
        send_n(PMAX, 4, IDLE);
        check("sq_pulses", mv_count - base, 2);
        check("sq_period", int'(period), 8);
        check("sq_duty", int'(duty_cycle), 128);
        check("sq_locked", int'(locked), 1);

        // Dead-band noise inside each phase
        do_reset();
        base = mv_count;
        send(NMAX, IDLE);
        for (int k = 0; k < 2; k++) begin
            send(PMAX, IDLE); send(PMAX, IDLE); send(NOISEN, IDLE); send(PMAX, IDLE);
            send(NMAX, IDLE); send(NMAX, IDLE); send(NOISEP, IDLE); send(NMAX, IDLE);
        end
        send(PMAX, IDLE);
`ifdef PERIOD_DETECTOR_HYSTERESIS_EN
        check("noise_pulses", mv_count - base, 2);
        check("noise_period", int'(period), 8);
`else
        check("noise_pulses", mv_count - base, 6);
        check("noise_period", int'(period), 2);
`endif
        check("noise_duty", int'(duty_cycle), 128);

        // 3 high / 9 low at nominal strobe spacing, with latency
        do_reset();
        base = mv_count;
        send(NMAX, 1040);
        send_n(PMAX, 3, 1040);
        send_n(NMAX, 9, 1040);
        send(PMAX, 1040);
        check("d39_pulses", mv_count - base, 1);
        check("d39_period", int'(period), 12);
        check("d39_duty", int'(duty_cycle), 64);
        check("d39_latency", mv_cyc - last_edge, PERCENT_WIDTH + 1);

        // Constant high until the high counter overflows
        base = mv_count;
        send_n(PMAX, 1 << PERIOD_WIDTH, IDLE);
        check("ovf_locked", int'(locked), 0);
        check("ovf_pulses", mv_count - base, 0);
        check("ovf_period_hold", int'(period), 12);
        check("ovf_duty_hold", int'(duty_cycle), 64);

        // Reset two edges into a division
        do_reset();
        send(NMAX, IDLE);
        send_n(PMAX, 2, IDLE);
        send_n(NMAX, 2, IDLE);
        send(PMAX, IDLE);
        send_n(NMAX, 2, IDLE);
        check("pre_period", int'(period), 4);
        check("pre_duty", int'(duty_cycle), 128);
        check("pre_locked", int'(locked), 1);
        base = mv_count;
        send(PMAX, 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("abort_period", int'(period), 0);
        check("abort_duty", int'(duty_cycle), 0);
        check("abort_mv", int'(measure_valid), 0);
        check("abort_locked", int'(locked), 0);
        repeat (20) @(posedge clk);
        #1;
        check("abort_no_pulse", mv_count - base, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
